// File: rtl/tff_to_jkff_bank.sv
// JK-style register bank built from T flip-flop cores.
// Each bit is a T flip-flop wrapped with conversion logic, t = (j & ~q) | (k & q),
// so that the bit behaves as a JK flip-flop.
// Optional feature macro TFF_TOGGLE_CNT_EN adds the toggle_cnt port and a
// saturating counter of individual bit toggles.

module tff #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  // T core: synchronous reset, toggles when t is high
  always_ff @(posedge clk) begin
    if (!rst_n) q <= RESET_BIT;
    else        q <= q ^ t;
  end

endmodule

module tff_to_jkff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             changed
`ifdef TFF_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
    $error("tff_to_jkff_bank: WIDTH must be 1..32 and CNT_W at least 1");
  end

  logic [WIDTH-1:0] t;

  // JK-to-T conversion; an invalid command forces t to zero so j/k are ignored
  always_comb begin
    t = '0;
    if (cmd_valid) t = (j & ~q) | (k & q);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff #(
      .RESET_BIT (RESET_VAL[i])
    ) u_tff (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  // One-cycle pulse whenever any bit toggled at the previous edge
  always_ff @(posedge clk) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |t;
  end

`ifdef TFF_TOGGLE_CNT_EN
  // Sum is formed six bits wider than the counter so adding up to 32 toggles
  // can never wrap before the clamp.
  localparam int SUM_W = CNT_W + 6;

  function automatic logic [5:0] popcount(input logic [WIDTH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int b = 0; b < WIDTH; b++) n = n + 6'(v[b]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] s);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    else                           return s[CNT_W-1:0];
  endfunction

  logic [SUM_W-1:0] cnt_sum;

  // Widened running total before saturation
  always_comb begin
    cnt_sum = SUM_W'(toggle_cnt) + SUM_W'(popcount(t));
  end

  // Saturating toggle-event counter; t is zero on idle cycles so it holds
  always_ff @(posedge clk) begin
    if (!rst_n) toggle_cnt <= '0;
    else        toggle_cnt <= sat_cnt(cnt_sum);
  end
`endif

endmodule
